mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//   Iterative multiply/divide unit for the MIPS core; consumes the EX-stage operands
//   (register rs and the selected operand B, i.e. rt or the extended immediate).
//   Executes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers.
//   Serves MTHI/MTLO writes. Exposes busy so the hazard unit stalls MFHI/MFLO
//   and further MDU ops.
// PARAMETERS
//   WIDTH    32  operand / HI / LO width; iteration count equals WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      launch op; sampled only in IDLE
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in   WIDTH  multiplicand / dividend (rs)
//   b        in   WIDTH  multiplier / divisor (operand B)
//   hi_we    in   1      MTHI: HI <= wdata
//   lo_we    in   1      MTLO: LO <= wdata
//   wdata    in   WIDTH  MTHI/MTLO data
//   busy     out  1      operation in progress
//   done     out  1      one-cycle pulse; HI/LO hold the new result
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async)
//     - state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0.
//   FSM: IDLE -> CALC -> FIX -> IDLE
//   IDLE
//     - start=1 at edge E0: latch |a| and |b| (signed ops) or raw a/b (unsigned ops).
//     - Latch result signs; counter=0; go to CALC.
//     - busy=1 from E0 onward.
//   CALC
//     - One radix-2 step per edge.
//     - Multiply: shift-add into a 2*WIDTH accumulator.
//     - Divide: restoring shift-subtract.
//     - Leaves after WIDTH steps, at edge E32.
//   FIX (edge E33)
//     - Apply signs: product negated if sign(a)^sign(b).
//     - Quotient negated if sign(a)^sign(b); remainder takes sign(a).
//     - Write HI/LO and return to IDLE.
//     - done=1 and busy=0 in the cycle after E33; done drops at the next edge.
//   Results
//     - MULT/MULTU: {HI,LO} = 64-bit product.
//     - DIV/DIVU: LO = quotient, HI = remainder.
//     - Divide by zero (b==0): HI=a, LO=all-ones. Completes with normal latency.
//     - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap, no flag.
//   Boundary rules
//     - start while busy: ignored.
//     - hi_we/lo_we while busy: ignored; the hazard unit guarantees a stall.
//     - hi_we/lo_we in IDLE: write at that edge. If start is also high, start wins
//       and the MT write is discarded.
//     - hi/lo keep their old values during CALC and change only at E33.
//     - rst mid-operation: abort to reset values immediately; no partial write.
// CONFIGURATION
//   MDU_FAST_MUL_EN defined
//     - MULT/MULTU use a single-cycle WIDTH x WIDTH product.
//     - Sequence is IDLE -> FIX: HI/LO written at E1, done=1 in the cycle after E1.
//     - Divides are unchanged.
//   MDU_FAST_MUL_EN undefined
//     - All ops are iterative, with results written at E33.
// TESTING
//   1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF
//        -> HI=0xFFFFFFFE, LO=0x00000001; done pulse after E33; busy high E0..E33.
//   2. MULT a=0xFFFFFFFD (-3) b=7
//        -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//   3. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU a=7 b=2 -> LO=3, HI=1.
//   4. DIV a=0x12345678 b=0 -> HI=0x12345678, LO=0xFFFFFFFF.
//      DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
//   5. start re-asserted and hi_we=1 at E5 of a running op -> both ignored.
//      rst pulsed at E10 -> busy=0, done=0, hi=lo=0; no done pulse follows.
//   6. With MDU_FAST_MUL_EN: MULT a=0x00010000 b=0x00010000
//        -> HI=1, LO=0 written at E1; done after E1.
//      Same op without the macro -> result at E33.

Source files
------------

// File: rtl/mdu.sv
// ============================================================================
// Module : mdu
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO registers.
// Optional macro MDU_FAST_MUL_EN: single-cycle MULT/MULTU (IDLE -> FIX).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   md;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem, div_zero;

    // op[0]=0 selects the signed variants (MULT, DIV)
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, md})
                             : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]     div_tmp, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;
    assign div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_tmp - {1'b0, md};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_step = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = div_zero ? {WIDTH{1'b1}}
                    : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) begin
`ifdef MDU_FAST_MUL_EN
                state_nx = op[1] ? CALC : FIX;
`else
                state_nx = CALC;
`endif
            end
            CALC: if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            md       <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= op[1] & (b == '0);
                        cnt      <= '0;
                        if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, abs_a};
                            md  <= abs_b;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            acc <= fast_prod;
`else
                            acc <= {{WIDTH{1'b0}}, abs_b};
`endif
                            md  <= abs_a;
                        end
                    end else begin
                        // MT writes only land when no operation is launched
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_step : mul_step;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// Module : tb_mdu
// Scoreboard bench for mdu: randomized ops against an arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: {HI,LO} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {63'b0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("hi", {32'b0, hi}, {32'b0, e[63:32]});
                    check("lo", {32'b0, lo}, {32'b0, e[31:0]});
                end
            end
        end
    end

    // disturb_at: negedge index at which start/hi_we/lo_we are re-asserted (0 = none)
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit mt_with_start, input int disturb_at);
        logic [31:0] hi0, lo0;
        int n, lat, bad_busy, bad_hold;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        hi_we = mt_with_start; lo_we = mt_with_start; wdata = $urandom;
        hi0 = hi; lo0 = lo;
        @(posedge clk);
        exp_q.push_back(model(o, x, y));
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = (FAST && !o[1]) ? 2 : 34;
        n = 0; bad_busy = 0; bad_hold = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
            if (n >= 200) begin
                check("done_timeout", 64'(n), 64'(lat));
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if (hi !== hi0 || lo !== lo0) bad_hold++;
            if (n == disturb_at) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
                wdata = $urandom; op = 2'($urandom);
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("busy_cycles_low", 64'(bad_busy), 64'd0);
        check("hilo_changed_early", 64'(bad_hold), 64'd0);
        check("busy_with_done", {63'b0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {60'b0, busy, done, (hi != 0), (lo != 0)}, 64'd0);
        rst = 1'b0;

        // MT writes in IDLE
        @(negedge clk); hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hBEEF_0002;
        @(negedge clk); lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'hCAFE_0001, 32'hBEEF_0002});

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 0);
        run_op(2'd3, 32'd7,         32'd2,         1'b0, 0);
        run_op(2'd2, 32'h1234_5678, 32'd0,         1'b0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'd2, 32'h8765_4321, 32'd0,         1'b0, 0);
        run_op(2'd3, 32'h8765_4321, 32'd0,         1'b0, 0);
        run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);
        run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 0);
        run_op(2'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 5);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1);

        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), pick(), pick(), 1'($urandom), 0);

        // Reset mid-operation: immediate clear, no later done pulse
        @(negedge clk); start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("abort_reset", {60'b0, busy, done, (hi != 0), (lo != 0)}, 64'd0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("no_done_after_abort", 64'(pulses), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
